// File: rtl/i2c_wb_bridge_if.sv
// WISHBONE classic bundle between the I2C bridge (master side) and the control-bus intercon.
// Signal names are as seen from the master; the slave modport mirrors the directions.
interface i2c_wb_bridge_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [19:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/i2c_wb_bridge.sv
// I2C target that turns each 4-byte word into one WISHBONE access on the control bus.
// SCL is held low while a bus cycle is pending; cycles end on ack/err/rty or after WB_TIMEOUT+1 clocks.
module i2c_wb_bridge #(
  parameter logic [6:0] DEV_ADDR   = 7'h2A,
  parameter int         FILTER_LEN = 3,
  parameter int         WB_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            scl_oe_o,
  output logic            sda_oe_o,
  output logic            busy_o,
  i2c_wb_bridge_if.master wb
);
  localparam int TW = (WB_TIMEOUT < 2) ? 1 : $clog2(WB_TIMEOUT + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEVADDR, ST_ACK_DEV, ST_ADDR_RX, ST_DATA_RX, ST_WB_WR,
    ST_ACK_DATA, ST_WB_RD, ST_DATA_TX, ST_MACK, ST_IGNORE
  } state_t;

  logic [1:0]            r_scl_sync, r_sda_sync;
  logic [FILTER_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                  r_scl_f, r_sda_f, r_scl_d, r_sda_d;

  // Idle bus is high, so the input path resets high to avoid a phantom START.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_hist <= '1;
      r_sda_hist <= '1;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
      r_scl_hist <= FILTER_LEN'({r_scl_hist, r_scl_sync[1]});
      r_sda_hist <= FILTER_LEN'({r_sda_hist, r_sda_sync[1]});
      if (&r_scl_hist)       r_scl_f <= 1'b1;
      else if (~|r_scl_hist) r_scl_f <= 1'b0;
      if (&r_sda_hist)       r_sda_f <= 1'b1;
      else if (~|r_sda_hist) r_sda_f <= 1'b0;
      r_scl_d    <= r_scl_f;
      r_sda_d    <= r_sda_f;
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;

  state_t        r_state, w_state;
  logic [3:0]    r_bitcnt, w_bitcnt;
  logic [1:0]    r_bytecnt, w_bytecnt;
  logic [7:0]    r_shift, w_shift;
  logic [19:0]   r_adr, w_adr;
  logic [31:0]   r_wdat, w_wdat;
  logic [31:0]   r_rdat, w_rdat;
  logic          r_rw, w_rw;
  logic          r_ack_ok, w_ack_ok;
  logic          r_sda_oe, w_sda_oe;
  logic          r_scl_oe, w_scl_oe;
  logic          r_cyc, w_cyc;
  logic          r_we, w_we;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          w_wb_done;
  logic [31:0]   w_rd_word;

  assign w_wb_done = wb.ack_i | wb.err_i | wb.rty_i | (r_tmo == TW'(WB_TIMEOUT));
  assign w_rd_word = wb.ack_i ? wb.dat_i : 32'hFFFF_FFFF;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_bitcnt  <= '0;
      r_bytecnt <= '0;
      r_shift   <= '0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_rw      <= 1'b0;
      r_ack_ok  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_tmo     <= '0;
    end else begin
      r_state   <= w_state;
      r_bitcnt  <= w_bitcnt;
      r_bytecnt <= w_bytecnt;
      r_shift   <= w_shift;
      r_adr     <= w_adr;
      r_wdat    <= w_wdat;
      r_rdat    <= w_rdat;
      r_rw      <= w_rw;
      r_ack_ok  <= w_ack_ok;
      r_sda_oe  <= w_sda_oe;
      r_scl_oe  <= w_scl_oe;
      r_cyc     <= w_cyc;
      r_we      <= w_we;
      r_tmo     <= w_tmo;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_bitcnt  = r_bitcnt;
    w_bytecnt = r_bytecnt;
    w_shift   = r_shift;
    w_adr     = r_adr;
    w_wdat    = r_wdat;
    w_rdat    = r_rdat;
    w_rw      = r_rw;
    w_ack_ok  = r_ack_ok;
    w_sda_oe  = r_sda_oe;
    w_scl_oe  = r_scl_oe;
    w_cyc     = r_cyc;
    w_we      = r_we;
    w_tmo     = r_cyc ? r_tmo + 1'b1 : '0;

    // Bit counts 0..8 are data bits; 9 marks the ACK clock of a received byte.
    if (w_scl_rise) begin
      if (r_bitcnt < 4'd8) begin
        w_shift  = {r_shift[6:0], r_sda_f};
        w_bitcnt = r_bitcnt + 4'd1;
      end else if (r_state == ST_MACK) begin
        w_shift = {r_shift[6:0], r_sda_f};
      end
    end

    if (w_stop) begin
      w_state  = ST_IDLE;
      w_sda_oe = 1'b0;
      w_scl_oe = 1'b0;
      w_cyc    = 1'b0;
      w_we     = 1'b0;
    end else if (w_start) begin
      w_state  = ST_DEVADDR;
      w_bitcnt = '0;
      w_sda_oe = 1'b0;
      w_scl_oe = 1'b0;
      w_cyc    = 1'b0;
      w_we     = 1'b0;
    end else begin
      case (r_state)
        ST_DEVADDR: if (w_scl_fall && r_bitcnt == 4'd8) begin
          if (r_shift[7:1] == DEV_ADDR) begin
            w_sda_oe = 1'b1;
            w_rw     = r_shift[0];
            w_state  = ST_ACK_DEV;
          end else begin
            w_state = ST_IGNORE;
          end
        end
        ST_ACK_DEV: if (w_scl_fall) begin
          w_sda_oe  = 1'b0;
          w_bitcnt  = '0;
          w_bytecnt = '0;
          if (r_rw) begin
            w_scl_oe = 1'b1;
            w_cyc    = 1'b1;
            w_we     = 1'b0;
            w_tmo    = '0;
            w_state  = ST_WB_RD;
          end else begin
            w_state = ST_ADDR_RX;
          end
        end
        ST_ADDR_RX: if (w_scl_fall) begin
          if (r_bitcnt == 4'd8) begin
            case (r_bytecnt)
              2'd0:    w_adr[19:16] = r_shift[3:0];
              2'd1:    w_adr[15:8]  = r_shift;
              default: w_adr[7:0]   = {r_shift[7:2], 2'b00};
            endcase
            w_sda_oe = 1'b1;
            w_bitcnt = 4'd9;
          end else if (r_bitcnt == 4'd9) begin
            w_sda_oe = 1'b0;
            w_bitcnt = '0;
            if (r_bytecnt == 2'd2) begin
              w_bytecnt = '0;
              w_state   = ST_DATA_RX;
            end else begin
              w_bytecnt = r_bytecnt + 2'd1;
            end
          end
        end
        ST_DATA_RX: if (w_scl_fall) begin
          if (r_bitcnt == 4'd8) begin
            w_wdat = {r_wdat[23:0], r_shift};
            if (r_bytecnt == 2'd3) begin
              w_scl_oe = 1'b1;
              w_cyc    = 1'b1;
              w_we     = 1'b1;
              w_tmo    = '0;
              w_state  = ST_WB_WR;
            end else begin
              w_sda_oe = 1'b1;
              w_bitcnt = 4'd9;
            end
          end else if (r_bitcnt == 4'd9) begin
            w_sda_oe  = 1'b0;
            w_bitcnt  = '0;
            w_bytecnt = r_bytecnt + 2'd1;
          end
        end
        ST_WB_WR: if (w_wb_done) begin
          w_cyc    = 1'b0;
          w_we     = 1'b0;
          w_ack_ok = wb.ack_i;
          w_sda_oe = wb.ack_i;
          w_state  = ST_ACK_DATA;
        end
        ST_ACK_DATA: begin
          w_scl_oe = 1'b0;
          if (w_scl_fall) begin
            w_sda_oe = 1'b0;
            if (r_ack_ok) begin
              w_adr     = r_adr + 20'd4;
              w_bitcnt  = '0;
              w_bytecnt = '0;
              w_state   = ST_DATA_RX;
            end else begin
              w_state = ST_IGNORE;
            end
          end
        end
        ST_WB_RD: if (w_wb_done) begin
          w_cyc     = 1'b0;
          w_rdat    = w_rd_word;
          w_sda_oe  = ~w_rd_word[31];
          w_adr     = r_adr + 20'd4;
          w_bitcnt  = '0;
          w_bytecnt = '0;
          w_state   = ST_DATA_TX;
        end
        ST_DATA_TX: begin
          w_scl_oe = 1'b0;
          if (w_scl_fall && r_bitcnt != 4'd0) begin
            w_rdat = {r_rdat[30:0], 1'b0};
            if (r_bitcnt == 4'd8) begin
              w_sda_oe = 1'b0;
              w_state  = ST_MACK;
            end else begin
              w_sda_oe = ~r_rdat[30];
            end
          end
        end
        ST_MACK: if (w_scl_fall) begin
          if (r_shift[0]) begin
            w_state = ST_IGNORE;
          end else if (r_bytecnt == 2'd3) begin
            w_scl_oe = 1'b1;
            w_cyc    = 1'b1;
            w_we     = 1'b0;
            w_tmo    = '0;
            w_state  = ST_WB_RD;
          end else begin
            w_bytecnt = r_bytecnt + 2'd1;
            w_bitcnt  = '0;
            w_sda_oe  = ~r_rdat[31];
            w_state   = ST_DATA_TX;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: w_state = ST_IDLE;
      endcase
    end
  end

  assign scl_oe_o = r_scl_oe;
  assign sda_oe_o = r_sda_oe;
  assign busy_o   = (r_state != ST_IDLE);
  assign wb.cyc_o = r_cyc;
  assign wb.stb_o = r_cyc;
  assign wb.we_o  = r_we;
  assign wb.adr_o = r_adr;
  assign wb.dat_o = r_wdat;
  assign wb.sel_o = 4'hF;
endmodule

// File: tb/tb_i2c_wb_bridge.sv
// Directed bench: an open-drain I2C master drives the bridge while a small WISHBONE responder answers its cycles.
module tb_i2c_wb_bridge;
  localparam int Q      = 10;
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_NONE = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1, m_sda = 1'b1, ign_stretch = 1'b0;
  logic scl_oe, sda_oe, busy;
  logic scl_line, sda_line;

  assign scl_line = m_scl & (~scl_oe | ign_stretch);
  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_wb_bridge_if wbif ();

  i2c_wb_bridge dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .scl_i    (scl_line),
    .sda_i    (sda_line),
    .scl_oe_o (scl_oe),
    .sda_oe_o (sda_oe),
    .busy_o   (busy),
    .wb       (wbif)
  );

  int n_checks = 0;
  int n_errors = 0;

  int          mode = M_ACK;
  logic [19:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [31:0] rd_q[$];
  int          rd_idx = 0;
  int          cyc_len = 0;
  int          viol = 0;
  logic        sda_seen = 1'b0;
  logic [31:0] ack_vec = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // WISHBONE responder: answers 3 clocks into a cycle according to mode.
  initial begin
    int   wait_cnt;
    logic prev_cyc;
    wait_cnt = 0;
    prev_cyc = 1'b0;
    wbif.ack_i = 1'b0;
    wbif.err_i = 1'b0;
    wbif.rty_i = 1'b0;
    wbif.dat_i = '0;
    forever begin
      @(negedge clk);
      wbif.ack_i = 1'b0;
      wbif.err_i = 1'b0;
      if (wbif.cyc_o && !scl_oe) viol++;
      if (sda_oe) sda_seen = 1'b1;
      if (wbif.cyc_o) begin
        if (!prev_cyc) begin
          log_adr.push_back(wbif.adr_o);
          log_dat.push_back(wbif.dat_o);
          log_we.push_back(wbif.we_o);
          log_sel.push_back(wbif.sel_o);
          wait_cnt = 0;
          cyc_len  = 0;
        end
        cyc_len++;
        wait_cnt++;
        if (wait_cnt == 3) begin
          if (mode == M_ACK) begin
            wbif.ack_i = 1'b1;
            if (!wbif.we_o && rd_idx < rd_q.size()) begin
              wbif.dat_i = rd_q[rd_idx];
              rd_idx++;
            end
          end else if (mode == M_ERR) begin
            wbif.err_i = 1'b1;
          end
        end
      end
      prev_cyc = wbif.cyc_o;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete in 80000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic q_wait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_release();
    int n;
    n = 0;
    m_scl = 1'b1;
    @(negedge clk);
    while (scl_line !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("scl_release_bound", 32'(n), 32'(0));
  endtask

  task automatic clock_bit(input logic b, output logic r);
    m_sda = b;
    q_wait();
    scl_release();
    q_wait();
    r = sda_line;
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    q_wait();
    scl_release();
    q_wait();
    m_sda = 1'b0;
    q_wait();
    m_scl = 1'b0;
    q_wait();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    q_wait();
    scl_release();
    q_wait();
    m_sda = 1'b1;
    q_wait();
    q_wait();
  endtask

  task automatic send(input logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, r);
    ack_vec = {ack_vec[30:0], ~r};
  endtask

  task automatic read_byte(input logic give_ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      d[i] = r;
    end
    clock_bit(~give_ack, r);
  endtask

  initial begin
    int          n0;
    logic [7:0]  rb;
    logic [63:0] rx;
    logic        r;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_scl_oe", 32'(scl_oe), 32'(0));
    check("rst_sda_oe", 32'(sda_oe), 32'(0));
    check("rst_cyc_stb_we", {29'd0, wbif.cyc_o, wbif.stb_o, wbif.we_o}, 32'(0));
    check("rst_adr", 32'(wbif.adr_o), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: write A5A51234 to 0x00104
    mode = M_ACK;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    check("t1_busy_after_start", 32'(busy), 32'(1));
    send(8'h54); send(8'h00); send(8'h01); send(8'h04);
    send(8'hA5); send(8'hA5); send(8'h12); send(8'h34);
    i2c_stop();
    check("t1_acks", ack_vec, 32'hFF);
    check("t1_n_cycles", 32'(log_adr.size() - n0), 32'(1));
    check("t1_adr", 32'(log_adr[n0]), 32'h00104);
    check("t1_dat", log_dat[n0], 32'hA5A51234);
    check("t1_we", 32'(log_we[n0]), 32'(1));
    check("t1_sel", 32'(log_sel[n0]), 32'hF);
    check("t1_busy_after_stop", 32'(busy), 32'(0));

    // 2: pointer write, repeated START, 8-byte read
    rd_q = {32'hDEADBEEF, 32'h01020304};
    rd_idx = 0;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    send(8'h54); send(8'h00); send(8'h00); send(8'h10);
    i2c_start();
    send(8'h55);
    rx = '0;
    for (int i = 0; i < 8; i++) begin
      read_byte(i != 7, rb);
      rx = {rx[55:0], rb};
    end
    i2c_stop();
    check("t2_acks", ack_vec, 32'h1F);
    check("t2_rx_word0", rx[63:32], 32'hDEADBEEF);
    check("t2_rx_word1", rx[31:0], 32'h01020304);
    check("t2_n_reads", 32'(log_adr.size() - n0), 32'(2));
    check("t2_adr0", 32'(log_adr[n0]), 32'h00010);
    check("t2_adr1", 32'(log_adr[n0 + 1]), 32'h00014);
    check("t2_we0", 32'(log_we[n0]), 32'(0));

    // 3: wrong device address
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    sda_seen = 1'b0;
    send(8'h56);
    send(8'h00);
    i2c_stop();
    check("t3_nack", ack_vec, 32'h0);
    check("t3_sda_never_driven", 32'(sda_seen), 32'(0));
    check("t3_no_cycle", 32'(log_adr.size() - n0), 32'(0));

    // 4a: err_i terminates the write -> 4th byte NACKed
    mode = M_ERR;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    send(8'h54); send(8'h00); send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    i2c_stop();
    check("t4a_acks", ack_vec, 32'hFE);
    check("t4a_adr", 32'(log_adr[n0]), 32'h00200);

    // 4b: no response -> timeout after WB_TIMEOUT+1 clocks, NACK
    mode = M_NONE;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    send(8'h54); send(8'h00); send(8'h00); send(8'h00);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    i2c_stop();
    check("t4b_acks", ack_vec, 32'hFE);
    check("t4b_cyc_len", 32'(cyc_len), 32'(256));
    check("t4b_adr", 32'(log_adr[n0]), 32'h00000);

    // 5a: STOP after two data bytes discards the word
    mode = M_ACK;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    send(8'h54); send(8'h00); send(8'h03); send(8'h00);
    send(8'h01); send(8'h02);
    i2c_stop();
    check("t5a_acks", ack_vec, 32'h3F);
    check("t5a_no_cycle", 32'(log_adr.size() - n0), 32'(0));

    // 5b: STOP while a read cycle is pending
    mode = M_NONE;
    i2c_start();
    send(8'h54); send(8'h00); send(8'h00); send(8'h40);
    i2c_start();
    send(8'h55);
    check("t5b_read_pending", 32'(wbif.cyc_o), 32'(1));
    m_sda = 1'b0;
    q_wait();
    ign_stretch = 1'b1;
    m_scl = 1'b1;
    q_wait();
    m_sda = 1'b1;
    q_wait();
    check("t5b_cyc_dropped", 32'(wbif.cyc_o), 32'(0));
    check("t5b_idle", 32'(busy), 32'(0));
    check("t5b_dropped_by_stop", 32'(cyc_len < 100), 32'(1));
    ign_stretch = 1'b0;
    q_wait();

    // 5c: reset during a stretched write
    i2c_start();
    send(8'h54); send(8'h00); send(8'h00); send(8'h00);
    send(8'hAA); send(8'hBB); send(8'hCC);
    for (int i = 7; i >= 0; i--) clock_bit(rb[i] ^ 1'b1, r);
    check("t5c_stretching", 32'(scl_oe), 32'(1));
    check("t5c_cyc_open", 32'(wbif.cyc_o), 32'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5c_scl_released", 32'(scl_oe), 32'(0));
    check("t5c_cyc_dropped", 32'(wbif.cyc_o), 32'(0));
    rst = 1'b0;
    m_scl = 1'b1;
    q_wait();
    m_sda = 1'b1;
    q_wait();
    check("t5c_idle", 32'(busy), 32'(0));

    // 6: two-word burst wrapping at the top of the address space
    mode = M_ACK;
    ack_vec = '0;
    n0 = log_adr.size();
    i2c_start();
    send(8'h54); send(8'h0F); send(8'hFF); send(8'hFC);
    send(8'h11); send(8'h11); send(8'h11); send(8'h11);
    send(8'h22); send(8'h22); send(8'h22); send(8'h22);
    i2c_stop();
    check("t6_acks", ack_vec, 32'hFFF);
    check("t6_n_cycles", 32'(log_adr.size() - n0), 32'(2));
    check("t6_adr0", 32'(log_adr[n0]), 32'hFFFFC);
    check("t6_adr1", 32'(log_adr[n0 + 1]), 32'h00000);
    check("t6_dat1", log_dat[n0 + 1], 32'h22222222);

    check("scl_held_while_cyc", 32'(viol), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/i2c_wb_bridge.md
Name: i2c_wb_bridge

Overview:
I2C target (slave) that lets the microcontroller on UC_SCL/UC_SDA act as a WISHBONE master on the 20-bit control bus (wbc). It is the responder end of the I2C protocol our LAB4/RFP I2C controllers initiate, and it plugs into wbc_intercon as a master port alongside pcic, turfc and hkmc. It stretches SCL while each WISHBONE cycle is pending, so the microcontroller sees one register access per 4-byte word.

Parameters:
DEV_ADDR, 7'h2A, 7-bit I2C device address the bridge answers to.
FILTER_LEN, 3, number of consecutive equal samples needed before a synchronized SCL/SDA level is accepted.
WB_TIMEOUT, 255, clk_i cycles to wait for ack_i/err_i/rty_i before abandoning a cycle.

Ports:
clk_i  in  1  control bus clock (wbc_clk); everything runs on it.
rst_i  in  1  synchronous, active-high reset.
scl_i  in  1  UC_SCL pad input (asynchronous).
sda_i  in  1  UC_SDA pad input (asynchronous).
scl_oe_o  out  1  1 = drive UC_SCL low (clock stretch); 0 = release. The top level does the tristating.
sda_oe_o  out  1  1 = drive UC_SDA low; 0 = release.
cyc_o, stb_o, we_o  out  1 each  WISHBONE master controls.
adr_o  out  20  word address; adr_o[1:0] is always 0.
dat_o  out  32  write data.
sel_o  out  4  always 4'hF.
dat_i  in  32  read data.
ack_i, err_i, rty_i  in  1 each  cycle terminations.
busy_o  out  1  high from START to STOP.

Behaviour:
- Reset: all outputs 0; state IDLE; address register 0. Reset in the middle of a cycle drops cyc_o and stb_o on the next edge and releases SCL/SDA.
- Input path: 2-FF synchronizer, then a FILTER_LEN majority/persistence filter.
- START is SDA falling while SCL is high; STOP is SDA rising while SCL is high. Both are detected in every state.
- START (including repeated START) goes to DEVADDR. STOP goes to IDLE, releases the bus, and aborts any open WB cycle by dropping cyc_o with no ack.
- Bits are sampled on filtered SCL rising edges. SDA outputs change only after a filtered SCL falling edge.
- States: IDLE, DEVADDR, ACK_DEV, ADDR_RX, DATA_RX, WB_WR, ACK_DATA, WB_RD, DATA_TX, MACK, IGNORE.
- DEVADDR:
  - Shift in 8 bits. If bits[7:1] ≠ DEV_ADDR, go to IGNORE: no ACK, SDA released until the next START or STOP.
  - On a match, ACK_DEV pulls SDA low for the 9th clock.
  - A R/W bit of 0 leads to ADDR_RX.
  - A R/W bit of 1 leads to WB_RD, stretching from the falling edge that ends the ACK.
- ADDR_RX: three bytes, each ACKed.
  - Byte 0 low nibble is adr[19:16]; its high nibble is ignored.
  - Byte 1 is adr[15:8]; byte 2 is adr[7:0], with bits [1:0] forced to 0.
  - Then go to DATA_RX with byte count 0.
- DATA_RX: bytes are assembled MSB first; byte 0 is dat_o[31:24].
  - Bytes 0-2 are ACKed normally.
  - After the 8th bit of byte 3, on the SCL falling edge: set scl_oe_o=1, go to WB_WR, and assert cyc_o/stb_o/we_o on the next clk_i.
- WB_WR:
  - On ack_i, drop cyc/stb the same cycle, go to ACK_DATA with ACK (SDA low), then release SCL.
  - On err_i, rty_i or timeout, do the same but NACK (SDA released).
  - After ACK: address += 4 (wraps 20'hFFFFC → 0) and return to DATA_RX. After NACK: go to IGNORE.
- WB_RD:
  - With SCL stretched, run a read cycle at adr_o.
  - On ack_i, latch dat_i. On err_i, rty_i or timeout, latch 32'hFFFFFFFF.
  - Drive bit 31 on SDA, release SCL one clk_i later, go to DATA_TX. Address += 4 after every read cycle.
- DATA_TX:
  - Shift 8 bits per byte, MSB first; SDA high is released, SDA low is driven.
  - Release SDA for MACK. A master ACK after bytes 0-2 continues with the next byte.
  - A master ACK after byte 3 goes to WB_RD, stretching from the falling edge.
  - A master NACK goes to IGNORE.
- A WB cycle is never left open: while cyc_o=1, at most WB_TIMEOUT+1 cycles pass before it drops.
- stb_o equals cyc_o; there is one single-beat classic cycle per word.
- A STOP before a word is complete discards the partial write; no WB cycle is issued.

Test Plan:
1. Write 0xA5A5_1234 to 0x00104: I2C W 0x54, 0x00, 0x01, 0x04, A5 A5 12 34, STOP → one WB write with adr_o=20'h00104, dat_o=32'hA5A51234, sel_o=4'hF; all 8 bytes ACKed; SCL stretched until ack_i.
2. Register-pointer read: W 0x54, 00 00 10, repeated START, R 0x55, read 8 bytes (ACK, ..., NACK), with the slave returning 0xDEADBEEF then 0x01020304 → WB reads at 0x00010 and 0x00014; SDA bytes DE AD BE EF 01 02 03 04; no third read.
3. Address mismatch: W 0x56 → no ACK; sda_oe_o stays 0 through STOP; cyc_o never asserts.
4. WB error: write to an address where the slave returns err_i → 4th data byte NACKed; a second write at 0x00 with no ack for 256 cycles → cyc_o drops at the timeout and the byte is NACKed.
5. Aborts:
   - STOP after 2 data bytes → no WB cycle.
   - STOP while WB_RD is waiting (ack_i held off) → cyc_o drops the next cycle; state is IDLE.
   - rst_i during a stretched write → scl_oe_o and cyc_o are 0 on the next edge.
6. Address wrap: a two-word burst write starting at 0xFFFFC → second WB write at adr_o=20'h00000.
